// File: rtl/float_recip_arbiter_pkg.sv
// Shared float-unit package: recip pipeline latency, tag pipeline depth and
// a clog2 helper used to size tag and pointer fields.
package float_recip_arbiter_pkg;

    localparam int unsigned FLOAT_RECIP_LATENCY = 4;
    localparam int unsigned LAT = FLOAT_RECIP_LATENCY;

    typedef logic [LAT-1:0] stage_mask_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/float_fast_recip.sv
// Fast float reciprocal: exponent/mantissa subtraction from a magic constant,
// carried through a FLOAT_RECIP_LATENCY deep pipeline that advances on ce.
module FloatFastRecip
    import float_recip_arbiter_pkg::*;
#(
    parameter int unsigned MANTISSA_SIZE = 23
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic [MANTISSA_SIZE+8:0] in_data,
    output logic [MANTISSA_SIZE+8:0] out_data
);

    localparam int unsigned FLOAT_SIZE = 9 + MANTISSA_SIZE;
    localparam logic [FLOAT_SIZE-2:0] MAGIC = {8'hFE, {MANTISSA_SIZE{1'b0}}};

    logic [FLOAT_RECIP_LATENCY-1:0][FLOAT_SIZE-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (ce) begin
            // Sign passes through; magnitude bits approximate 1/|x|.
            stage_d[0] = {in_data[FLOAT_SIZE-1], MAGIC - in_data[FLOAT_SIZE-2:0]};
            for (int unsigned i = 1; i < FLOAT_RECIP_LATENCY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign out_data = stage_q[FLOAT_RECIP_LATENCY-1];

endmodule

// File: rtl/float_recip_arbiter_rr.sv
// Round-robin grant: first asserted request at or after ptr, one-hot grant.
module rr_arbiter
    import float_recip_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_recip_arbiter.sv
// Shares one FloatFastRecip among NUM_REQ requesters; a tag pipeline moving
// in lockstep with the recip routes each result back to its issuer.
module float_recip_arbiter
    import float_recip_arbiter_pkg::*;
#(
    parameter int unsigned MANTISSA_SIZE = 23,
    parameter int unsigned NUM_REQ       = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   in_valid,
    input  logic [NUM_REQ*(9+MANTISSA_SIZE)-1:0] in_data,
    output logic [NUM_REQ-1:0]                   in_ready,
    output logic [NUM_REQ-1:0]                   out_valid,
    output logic [MANTISSA_SIZE+8:0]             out_data,
    input  logic [NUM_REQ-1:0]                   out_ready,
    output logic [2:0]                           inflight
);

    localparam int unsigned FLOAT_SIZE = 9 + MANTISSA_SIZE;
    localparam int unsigned TAG_W      = clog2(NUM_REQ);

    stage_mask_t                tag_valid_q, tag_valid_d;
    logic [LAT-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]         grant;
    logic                       ce, head_valid, issue;
    logic [TAG_W-1:0]           head_tag, issue_tag;
    logic [FLOAT_SIZE-1:0]      recip_in;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (TAG_W)
    ) u_rr (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    FloatFastRecip #(
        .MANTISSA_SIZE (MANTISSA_SIZE)
    ) u_recip (
        .clk      (clk),
        .ce       (ce),
        .in_data  (recip_in),
        .out_data (out_data)
    );

    assign head_valid = tag_valid_q[LAT-1];
    assign head_tag   = tag_q[LAT-1];
    // A stalled head freezes recip and tags together so they never drift apart.
    assign ce         = !(head_valid && !out_ready[head_tag]);

    always_comb begin
        issue_tag = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                issue_tag = TAG_W'(i);
            end
        end
        issue    = ce && (|grant);
        in_ready = ce ? grant : '0;
        recip_in = in_data[issue_tag*FLOAT_SIZE +: FLOAT_SIZE];

        out_valid = '0;
        if (head_valid) begin
            out_valid[head_tag] = 1'b1;
        end

        inflight = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            inflight = inflight + 3'(tag_valid_q[i]);
        end
    end

    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_d       = tag_q;
        rr_ptr_d    = rr_ptr_q;
        if (ce) begin
            tag_valid_d = {tag_valid_q[LAT-2:0], issue};
            tag_d       = {tag_q[LAT-2:0], issue_tag};
        end
        if (issue) begin
            rr_ptr_d = (32'(issue_tag) == NUM_REQ - 1) ? '0 : TAG_W'(issue_tag + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_float_recip_arbiter.sv
// Bench for float_recip_arbiter: directed scenarios with literal expectations
// plus a per-cycle model of grants, tags and an in-order result queue.
module tb_float_recip_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data;
    logic [31:0]  out_data;
    logic [2:0]   inflight;

    int errors = 0;
    int checks = 0;

    float_recip_arbiter #(
        .MANTISSA_SIZE (23),
        .NUM_REQ       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference reciprocal: 1/|x| approximated by subtracting the magnitude
    // bits from 0x7F000000 (so 2.0 -> 0.5 exactly), sign preserved.
    function automatic logic [31:0] recip_model(input logic [31:0] x);
        logic [30:0] mag;
        mag = 31'h7F000000 - x[30:0];
        return {x[31], mag};
    endfunction

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] data;
    } res_t;

    res_t       sb[$];
    logic       m_v[4];
    logic [1:0] m_tag[4];
    int         m_ptr;

    // Model state mirrors what the design holds after the most recent edge.
    always @(negedge clk) begin
        logic [3:0] e_grant, e_ovalid;
        logic       e_ce;
        int         cnt, idx, g;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
            m_ptr = 0;
            sb.delete();
        end else begin
            e_ce    = !(m_v[3] && !out_ready[m_tag[3]]);
            e_grant = '0;
            g       = -1;
            if (e_ce) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (g < 0 && in_valid[idx]) g = idx;
                end
                if (g >= 0) e_grant[g] = 1'b1;
            end
            e_ovalid = '0;
            if (m_v[3]) e_ovalid[m_tag[3]] = 1'b1;
            cnt = 0;
            for (int i = 0; i < 4; i++) cnt += int'(m_v[i]);

            chk("in_ready", 64'(in_ready), 64'(e_grant));
            chk("out_valid", 64'(out_valid), 64'(e_ovalid));
            chk("inflight", 64'(inflight), 64'(cnt));
            if (m_v[3] && sb.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(sb[0].data));
            end

            if (e_ce) begin
                if (m_v[3] && sb.size() > 0) void'(sb.pop_front());
                for (int i = 3; i > 0; i--) begin
                    m_v[i]   = m_v[i-1];
                    m_tag[i] = m_tag[i-1];
                end
                m_v[0]   = (g >= 0);
                m_tag[0] = 2'(g);
                if (g >= 0) begin
                    sb.push_back('{tag: 2'(g), data: recip_model(in_data[g*32 +: 32])});
                    m_ptr = (g + 1) % 4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t, r;
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 4'hF;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset_inflight", 64'(inflight), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);

        // Single operand 2.0 from requester 0.
        in_data[31:0] = 32'h40000000;
        in_valid      = 4'b0001;
        #1;
        chk("t1_in_ready", 64'(in_ready), 64'b0001);
        step();
        in_valid = '0;
        chk("t1_inflight", 64'(inflight), 64'd1);
        step();
        step();
        chk("t1_early_out_valid", 64'(out_valid), 64'd0);
        step();
        chk("t1_out_valid", 64'(out_valid), 64'b0001);
        chk("t1_out_data", 64'(out_data), 64'h3F000000);
        step();
        chk("t1_retired", 64'(inflight), 64'd0);

        // All four requesters for 8 cycles, from a fresh pointer.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h3F800000 + (i << 20);
        in_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) in_valid = '0;
            #1;
            chk("t2_grant", 64'(in_ready), (c < 8) ? 64'(1 << (c % 4)) : 64'd0);
            step();
            t = (c + 1 < 8) ? c + 1 : 8;
            r = (c - 3 < 0) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
            chk("t2_inflight", 64'(inflight), 64'(t - r));
            chk("t2_out_valid", 64'(out_valid),
                (c >= 3 && c - 3 < 8) ? 64'(1 << ((c - 3) % 4)) : 64'd0);
        end

        // Head addressed to requester 2 stalls for three cycles.
        out_ready          = 4'b1011;
        in_data[64 +: 32]  = 32'h40800000;
        in_valid           = 4'b0100;
        #1;
        chk("t3_grant", 64'(in_ready), 64'b0100);
        step();
        in_valid = '0;
        step();
        step();
        step();
        in_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_stall_out_valid", 64'(out_valid), 64'b0100);
            chk("t3_stall_out_data", 64'(out_data), 64'h3E800000);
            chk("t3_stall_in_ready", 64'(in_ready), 64'd0);
            chk("t3_stall_inflight", 64'(inflight), 64'd1);
            step();
        end
        out_ready = 4'hF;
        #1;
        chk("t3_resume_out_valid", 64'(out_valid), 64'b0100);
        chk("t3_resume_in_ready", 64'(in_ready), 64'b0001);
        step();
        in_valid = '0;
        chk("t3_resume_inflight", 64'(inflight), 64'd1);
        chk("t3_resume_out_valid_low", 64'(out_valid), 64'd0);
        repeat (5) step();

        // Reset with three operations in flight.
        in_data[32 +: 32] = 32'h3FC00000;
        in_valid          = 4'b0010;
        step();
        step();
        step();
        in_valid = '0;
        chk("t4_inflight_before", 64'(inflight), 64'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_inflight_after", 64'(inflight), 64'd0);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t4_no_out_valid", 64'(out_valid), 64'd0);
            step();
        end

        // Pointer wraps from 3 back to 0, so requester 1 wins over 3.
        in_data[96 +: 32] = 32'h41000000;
        in_valid          = 4'b1000;
        #1;
        chk("t5_grant3", 64'(in_ready), 64'b1000);
        step();
        in_valid = 4'b1010;
        #1;
        chk("t5_wrap_grant1", 64'(in_ready), 64'b0010);
        step();
        in_valid = '0;
        repeat (6) step();

        // Random valid/ready traffic.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
            step();
        end
        in_valid  = '0;
        out_ready = 4'hF;
        repeat (8) step();
        chk("drain_inflight", 64'(inflight), 64'd0);
        chk("drain_scoreboard", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/float_recip_arbiter.md
FLOAT_RECIP_ARBITER -- requirements
Module: float_recip_arbiter

Interface
REQ-001 SHALL have parameter MANTISSA_SIZE, default 23, mantissa width passed to the shared FloatFastRecip; FLOAT_SIZE = 9 + MANTISSA_SIZE.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8); TAG_W = clog2(NUM_REQ).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 SHALL have port in_data  input  NUM_REQ*FLOAT_SIZE  per-requester operand, requester i at slice i.
REQ-007 SHALL have port in_ready  output  NUM_REQ  per-requester accept; a transfer occurs when in_valid[i] and in_ready[i] are both high.
REQ-008 SHALL have port out_valid  output  NUM_REQ  one-hot result valid, addressed to the requester that issued the operand.
REQ-009 SHALL have port out_data  output  FLOAT_SIZE  result, shared by all requesters.
REQ-010 SHALL have port out_ready  input  NUM_REQ  per-requester result accept.
REQ-011 SHALL have port inflight  output  3  number of valid operations in the pipeline (0..4).

Function
REQ-012 SHALL instantiate exactly one FloatFastRecip (latency LAT = 4 ce-cycles) and share it among all requesters.
REQ-013 SHALL keep a tag pipeline of LAT stages (valid bit plus TAG_W tag) that advances on the same ce as the recip, so that the head stage always matches the recip output.
REQ-014 SHALL drive recip ce = !(head_valid && !out_ready[head_tag]); a stall freezes the recip and the tag pipeline together.
REQ-015 SHALL assert out_valid[head_tag] iff head_valid; all other out_valid bits low; out_data = recip out.
REQ-016 SHALL hold out_data and out_valid stable while stalled, until out_ready of the addressed requester goes high.
REQ-017 SHALL issue at most one operand per cycle, and only when ce is high; in_ready is all-zero when ce is low.
REQ-018 SHALL grant by round robin: search starts at rr_ptr, the first index with in_valid high is granted, and in_ready is one-hot for that index only.
REQ-019 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ on each transfer; rr_ptr is unchanged when there is no transfer.
REQ-020 SHALL insert a bubble into tag stage 0 (valid = 0) on a ce cycle with no transfer; the recip input then carries don't-care data.
REQ-021 SHALL sustain one result per cycle when all addressed out_ready are high; no cycle is lost at a retire-plus-issue boundary.
REQ-022 SHALL update inflight as the count of valid tag stages: +1 on issue, -1 on retire, net 0 when both occur in the same cycle.
REQ-023 SHALL make in_ready independent of out_valid per requester: a requester may issue and retire in the same cycle.
REQ-024 SHALL not depend combinationally on in_data for any output except through the recip.

Reset
REQ-025 SHALL, while reset is high, clear all tag-valid bits, set rr_ptr = 0 and set inflight = 0; out_valid and in_ready are then 0 in the next cycle.
REQ-026 SHALL discard operations in flight at reset; their results are never presented.
REQ-027 SHALL not reset the recip datapath; the valid bits mask its contents.

Structure
REQ-028 SHALL define LAT = 4 and the clog2 helper in the shared float package, next to the FloatFastRecip latency constant.
REQ-029 SHALL factor the round-robin grant into one sub-module, rr_arbiter (NUM_REQ parameter; inputs req and ptr; output grant one-hot), reusable for other shared float units.

Verification
REQ-030 SHALL cover: requester 0 sends 0x40000000 (2.0), out_ready all high -> out_valid = 0b0001 exactly 4 cycles later, out_data within 5% of 0x3F000000.
REQ-031 SHALL cover: all 4 requesters hold in_valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 back-to-back, results returned in the same order, inflight saturates at 4.
REQ-032 SHALL cover: the head is addressed to requester 2 with out_ready[2] low for 3 cycles -> out_data and out_valid held, in_ready = 0, inflight unchanged, then resumes with no loss.
REQ-033 SHALL cover: reset asserted with 3 operations in flight -> next cycle inflight = 0, no out_valid for the following 6 cycles without new input.
REQ-034 SHALL cover: in_valid only on requesters 1 and 3 after a grant to 3 -> next grant 1 (pointer wrap).
REQ-035 SHALL cover: random valid/ready over 10k cycles -> every accepted operand is returned exactly once to its issuer, in order, and matches the reference model of a standalone FloatFastRecip bit-exactly.
